// File: rtl/ysyx_22050612_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_pkg
// Shared constants for the NPC writeback path.
//   XLEN     : default register data width
//   REG_AW   : default register index width (2**REG_AW registers)
//   req_id_e : writeback requester IDs (REQ_EXU = 0, REQ_LSU = 1)
// ---------------------------------------------------------------------------
package ysyx_22050612_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage : ysyx_22050612_pkg

// File: rtl/ysyx_22050612_rf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_rf_wb_arbiter_if
// Bundles the writeback requests, decode scoreboard ports and register-file
// write port of ysyx_22050612_rf_wb_arbiter.
//
// Handshake (both requesters): a transfer happens in any cycle where
// reqN_valid && reqN_ready. Once valid is raised, the requester holds valid,
// addr and data stable until that transfer. ready is combinational from the
// valids and at most one ready is high per cycle.
//
//   slave  modport : arbiter side (takes requests, drives ready/busy/rf_*)
//   master modport : environment side (EXU/LSU/decode/register file)
//   dbg_last_grant : requester granted most recently (arbiter state)
//   dbg_pending    : scoreboard bitmap, one bit per register
// ---------------------------------------------------------------------------
interface ysyx_22050612_rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    logic                      req0_valid;
    logic [ADDR_WIDTH-1:0]     req0_addr;
    logic [DATA_WIDTH-1:0]     req0_data;
    logic                      req0_ready;
    logic                      req1_valid;
    logic [ADDR_WIDTH-1:0]     req1_addr;
    logic [DATA_WIDTH-1:0]     req1_data;
    logic                      req1_ready;
    logic                      issue_valid;
    logic [ADDR_WIDTH-1:0]     issue_rd;
    logic [ADDR_WIDTH-1:0]     rs1;
    logic [ADDR_WIDTH-1:0]     rs2;
    logic                      rs1_busy;
    logic                      rs2_busy;
    logic                      rf_wen;
    logic [ADDR_WIDTH-1:0]     rf_waddr;
    logic [DATA_WIDTH-1:0]     rf_wdata;
    logic                      dbg_last_grant;
    logic [(1<<ADDR_WIDTH)-1:0] dbg_pending;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  issue_valid, issue_rd, rs1, rs2,
        output req0_ready, req1_ready, rs1_busy, rs2_busy,
        output rf_wen, rf_waddr, rf_wdata,
        output dbg_last_grant, dbg_pending
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output issue_valid, issue_rd, rs1, rs2,
        input  req0_ready, req1_ready, rs1_busy, rs2_busy,
        input  rf_wen, rf_waddr, rf_wdata,
        input  dbg_last_grant, dbg_pending
    );

endinterface : ysyx_22050612_rf_wb_arbiter_if

// File: rtl/ysyx_22050612_rr_arb2.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_rr_arb2
// Two-way round-robin arbiter with combinational grant.
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid[1:0]  : request valids (bit N = requester N)
//   grant[1:0]  : one-hot or zero grant; forced 0 while rst_n is low
//   last_grant  : requester granted most recently (state, exposed for debug)
// On a tie the requester that was not granted last wins. Reset state is
// REQ_LSU so requester 0 wins the first tie. Every grant is a transfer, so
// the state updates on every grant.
// ---------------------------------------------------------------------------
module ysyx_22050612_rr_arb2
    import ysyx_22050612_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output req_id_e    last_grant
);

    req_id_e last_grant_q;
    req_id_e last_grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        // rst_n gating keeps ready low for the whole reset pulse, not just
        // until the first edge.
        if (rst_n) begin
            if (valid[0] && (!valid[1] || last_grant_q == REQ_LSU)) begin
                grant[0] = 1'b1;
            end else if (valid[1]) begin
                grant[1] = 1'b1;
            end
        end
        if (grant[0]) begin
            last_grant_d = REQ_EXU;
        end else if (grant[1]) begin
            last_grant_d = REQ_LSU;
        end
    end

    assign last_grant = last_grant_q;

endmodule : ysyx_22050612_rr_arb2

// File: rtl/ysyx_22050612_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_rf_wb_arbiter
// Shares the single register-file write port between the EXU result path
// (req0) and the LSU load path (req1), and keeps a pending-write bitmap so
// decode can stall on read-after-write hazards.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ysyx_22050612_rf_wb_arbiter_if.slave
//                requests in, ready out; issue/rs in, busy out;
//                registered rf_wen/rf_waddr/rf_wdata out (1-cycle latency).
// Writes to x0 are accepted but never enabled at the register file.
// Optional: define YSYX_22050612_RF_WB_TRACE_EN for a per-write trace line
// (simulation only) with a 64-bit cycle counter.
// ---------------------------------------------------------------------------
module ysyx_22050612_rf_wb_arbiter
    import ysyx_22050612_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_AW,
    parameter int DATA_WIDTH = XLEN
) (
    input logic                          clk,
    input logic                          rst_n,
    ysyx_22050612_rf_wb_arbiter_if.slave bus
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [1:0]            grant;
    req_id_e               last_grant;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  rf_wen_q,   rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]       pending_q,  pending_d;

    ysyx_22050612_rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .grant      (grant),
        .last_grant (last_grant)
    );

    assign accept   = grant[0] | grant[1];
    assign sel_addr = grant[1] ? bus.req1_addr : bus.req0_addr;
    assign sel_data = grant[1] ? bus.req1_data : bus.req0_data;

    always_comb begin
        rf_wen_d   = accept && (sel_addr != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (accept) begin
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
        end

        // Clear first, then set: a new producer issued in the same cycle as
        // an older write commits keeps the register busy.
        pending_d = pending_q;
        if (accept) begin
            pending_d[sel_addr] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_rd != '0) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.req0_ready     = grant[0];
    assign bus.req1_ready     = grant[1];
    // Not bypassed: a write accepted this cycle still reads busy until the edge.
    assign bus.rs1_busy       = pending_q[bus.rs1];
    assign bus.rs2_busy       = pending_q[bus.rs2];
    assign bus.rf_wen         = rf_wen_q;
    assign bus.rf_waddr       = rf_waddr_q;
    assign bus.rf_wdata       = rf_wdata_q;
    assign bus.dbg_last_grant = last_grant;
    assign bus.dbg_pending    = pending_q;

`ifdef YSYX_22050612_RF_WB_TRACE_EN
    logic [63:0] cycle_q;
    req_id_e     wb_src_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q  <= '0;
            wb_src_q <= REQ_EXU;
        end else begin
            cycle_q  <= cycle_q + 64'd1;
            if (accept) begin
                wb_src_q <= grant[1] ? REQ_LSU : REQ_EXU;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rf_wen_q) begin
            $display("rf_wb cycle=%0d src=%0d waddr=%h wdata=%h",
                     cycle_q, wb_src_q, rf_waddr_q, rf_wdata_q);
        end
    end
`else
`endif

endmodule : ysyx_22050612_rf_wb_arbiter

// File: tb/tb_ysyx_22050612_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050612_rf_wb_arbiter
// Directed testbench for ysyx_22050612_rf_wb_arbiter. Inputs change 1 time
// unit after a rising edge; outputs are sampled 1 time unit after inputs
// settle or after an edge, never on the edge itself.
// ---------------------------------------------------------------------------
module tb_ysyx_22050612_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 64;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ysyx_22050612_rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ysyx_22050612_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req0_valid = v;
        bus.req0_addr  = a;
        bus.req0_data  = d;
    endtask

    task automatic drive1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req1_valid = v;
        bus.req1_addr  = a;
        bus.req1_data  = d;
    endtask

    task automatic issue(input logic v, input logic [AW-1:0] rd);
        bus.issue_valid = v;
        bus.issue_rd    = rd;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        issue(1'b0, '0);
        bus.rs1 = '0;
        bus.rs2 = '0;

        // Reset state
        repeat (2) tick();
        check_eq("rst_rf_wen",     bus.rf_wen,         64'd0);
        check_eq("rst_rf_waddr",   bus.rf_waddr,       64'd0);
        check_eq("rst_rf_wdata",   bus.rf_wdata,       64'd0);
        check_eq("rst_pending",    bus.dbg_pending,    64'd0);
        check_eq("rst_last_grant", bus.dbg_last_grant, 64'd1);
        bus.req0_valid = 1'b1;
        #1;
        check_eq("rst_ready0", bus.req0_ready, 64'd0);
        bus.req0_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();

        // req0 alone: addr 5, data 0xAA
        drive0(1'b1, 5'd5, 64'hAA);
        #1;
        check_eq("solo0_ready0", bus.req0_ready, 64'd1);
        check_eq("solo0_ready1", bus.req1_ready, 64'd0);
        tick();
        drive0(1'b0, '0, '0);
        check_eq("solo0_wen",   bus.rf_wen,   64'd1);
        check_eq("solo0_waddr", bus.rf_waddr, 64'd5);
        check_eq("solo0_wdata", bus.rf_wdata, 64'hAA);

        // req1 alone: addr 9, leaves last_grant = req1
        drive1(1'b1, 5'd9, 64'h99);
        #1;
        check_eq("solo1_ready1", bus.req1_ready, 64'd1);
        check_eq("solo1_ready0", bus.req0_ready, 64'd0);
        tick();
        drive1(1'b0, '0, '0);
        check_eq("solo1_waddr", bus.rf_waddr,       64'd9);
        check_eq("solo1_wdata", bus.rf_wdata,       64'h99);
        check_eq("solo1_last",  bus.dbg_last_grant, 64'd1);

        // Both valid for 4 cycles: req0, req1, req0, req1
        drive0(1'b1, 5'd1, 64'h11);
        drive1(1'b1, 5'd2, 64'h22);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("tie_ready0_%0d", i), bus.req0_ready, (i % 2 == 0) ? 64'd1 : 64'd0);
            check_eq($sformatf("tie_ready1_%0d", i), bus.req1_ready, (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            check_eq($sformatf("tie_waddr_%0d", i), bus.rf_waddr, (i % 2 == 0) ? 64'd1 : 64'd2);
            check_eq($sformatf("tie_wdata_%0d", i), bus.rf_wdata, (i % 2 == 0) ? 64'h11 : 64'h22);
        end
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);

        // req1 writes x0: accepted, never enabled, no pending change
        drive1(1'b1, 5'd0, 64'hFF);
        #1;
        check_eq("x0_ready1", bus.req1_ready, 64'd1);
        tick();
        drive1(1'b0, '0, '0);
        check_eq("x0_wen",     bus.rf_wen,      64'd0);
        check_eq("x0_waddr",   bus.rf_waddr,    64'd0);
        check_eq("x0_wdata",   bus.rf_wdata,    64'hFF);
        check_eq("x0_pending", bus.dbg_pending, 64'd0);

        // issue rd 7, then commit it via req0
        issue(1'b1, 5'd7);
        tick();
        issue(1'b0, '0);
        bus.rs1 = 5'd7;
        #1;
        check_eq("raw7_busy",    bus.rs1_busy,    64'd1);
        check_eq("raw7_pending", bus.dbg_pending, 64'h80);
        drive0(1'b1, 5'd7, 64'h77);
        #1;
        check_eq("raw7_ready0",      bus.req0_ready, 64'd1);
        check_eq("raw7_busy_nobyp",  bus.rs1_busy,   64'd1);
        tick();
        drive0(1'b0, '0, '0);
        #1;
        check_eq("raw7_busy_clr", bus.rs1_busy, 64'd0);
        check_eq("raw7_wen",      bus.rf_wen,   64'd1);
        check_eq("raw7_waddr",    bus.rf_waddr, 64'd7);

        // same-cycle set and clear of x3: set wins
        issue(1'b1, 5'd3);
        tick();
        bus.rs2 = 5'd3;
        #1;
        check_eq("sc3_busy_pre", bus.rs2_busy, 64'd1);
        drive0(1'b1, 5'd3, 64'h33);
        #1;
        check_eq("sc3_ready0", bus.req0_ready, 64'd1);
        tick();
        issue(1'b0, '0);
        drive0(1'b0, '0, '0);
        #1;
        check_eq("sc3_busy",    bus.rs2_busy,    64'd1);
        check_eq("sc3_pending", bus.dbg_pending, 64'h8);
        check_eq("sc3_wen",     bus.rf_wen,      64'd1);
        check_eq("sc3_waddr",   bus.rf_waddr,    64'd3);

        // asynchronous reset mid-operation
        issue(1'b1, 5'd4);
        drive1(1'b1, 5'd6, 64'h66);
        tick();
        issue(1'b0, '0);
        drive1(1'b0, '0, '0);
        bus.rs1 = 5'd4;
        #1;
        check_eq("ar_pre_wen",   bus.rf_wen,   64'd1);
        check_eq("ar_pre_waddr", bus.rf_waddr, 64'd6);
        check_eq("ar_pre_busy",  bus.rs1_busy, 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("ar_wen",     bus.rf_wen,      64'd0);
        check_eq("ar_waddr",   bus.rf_waddr,    64'd0);
        check_eq("ar_busy1",   bus.rs1_busy,    64'd0);
        check_eq("ar_busy2",   bus.rs2_busy,    64'd0);
        check_eq("ar_pending", bus.dbg_pending, 64'd0);
        drive0(1'b1, 5'd10, 64'h1010);
        drive1(1'b1, 5'd11, 64'h1111);
        #1;
        check_eq("ar_ready0", bus.req0_ready, 64'd0);
        check_eq("ar_ready1", bus.req1_ready, 64'd0);
        tick();
        check_eq("ar_ready0_edge", bus.req0_ready, 64'd0);
        check_eq("ar_wen_edge",    bus.rf_wen,     64'd0);
        #2 rst_n = 1'b1;
        #1;
        // last_grant back to req1, so req0 wins the first tie
        check_eq("post_ready0", bus.req0_ready, 64'd1);
        check_eq("post_ready1", bus.req1_ready, 64'd0);
        tick();
        check_eq("post_wen",    bus.rf_wen,   64'd1);
        check_eq("post_waddr",  bus.rf_waddr, 64'd10);
        check_eq("post_wdata",  bus.rf_wdata, 64'h1010);
        #1;
        check_eq("post_alt_ready1", bus.req1_ready, 64'd1);
        check_eq("post_alt_ready0", bus.req0_ready, 64'd0);
        tick();
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        check_eq("post_alt_waddr", bus.rf_waddr, 64'd11);
        check_eq("post_alt_wdata", bus.rf_wdata, 64'h1111);
        tick();
        check_eq("idle_wen", bus.rf_wen, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ysyx_22050612_rf_wb_arbiter
